// File: rtl/ifetch_buf_if.sv
// Fetch-buffer signal bundle: PC request, instruction-memory read port and decode-side handshake.
// The slave modport is the buffer itself; master is whoever surrounds it.
interface ifetch_buf_if;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_exc;

    modport slave (
        input  pc, pc_valid, imem_rvalid, imem_rdata, flush, instr_ready,
        output pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_exc
    );

    modport master (
        output pc, pc_valid, imem_rvalid, imem_rdata, flush, instr_ready,
        input  pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_exc
    );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: one outstanding memory read, 2-entry in-order queue toward decode,
// misaligned PCs become fault entries without touching memory.
module ifetch_buf (
    input logic         Clk,
    input logic         Reset,
    ifetch_buf_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
        logic        exc;
    } entry_t;

    localparam logic [31:0] ResetPc    = 32'h0000_3000;
    localparam entry_t      ResetEntry = '{word: 32'h0, addr: ResetPc, exc: 1'b0};

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    entry_t      ent0_q, ent0_d;
    entry_t      ent1_q, ent1_d;
    logic [31:0] pc_lat_q, pc_lat_d;

    logic   accept;
    logic   aligned;
    logic   push;
    logic   pop;
    entry_t push_ent;

    assign aligned = (bus.pc[1:0] == 2'b00);
    // Reset also gates acceptance so nothing is requested while the block is held in reset.
    assign bus.pc_ready = (state_q == StIdle) && (count_q < 2'd2) && !bus.flush && !Reset;
    assign accept       = bus.pc_valid && bus.pc_ready;
    assign bus.imem_req  = accept && aligned;
    assign bus.imem_addr = bus.pc;
    assign pop           = (count_q != 2'd0) && bus.instr_ready && !bus.flush;

    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr       = ent0_q.word;
    assign bus.instr_pc    = ent0_q.addr;
    assign bus.instr_exc   = ent0_q.exc;

    always_comb begin
        state_d  = state_q;
        pc_lat_d = pc_lat_q;
        push     = 1'b0;
        push_ent = ResetEntry;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (aligned) begin
                        state_d  = StWait;
                        pc_lat_d = bus.pc;
                    end else begin
                        push     = 1'b1;
                        push_ent = '{word: 32'h0, addr: bus.pc, exc: 1'b1};
                    end
                end
            end
            StWait: begin
                if (bus.flush) begin
                    state_d = bus.imem_rvalid ? StIdle : StDrop;
                end else if (bus.imem_rvalid) begin
                    push     = 1'b1;
                    push_ent = '{word: bus.imem_rdata, addr: pc_lat_q, exc: 1'b0};
                    state_d  = StIdle;
                end
            end
            StDrop: begin
                // Leaving on the stale response even under flush avoids waiting for a read
                // that will never come.
                if (bus.imem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;

        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = push_ent;
                    else                 ent1_d = push_ent;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_ent;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            count_q  <= 2'd0;
            ent0_q   <= ResetEntry;
            ent1_q   <= ResetEntry;
            pc_lat_q <= ResetPc;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            pc_lat_q <= pc_lat_d;
        end
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: table of combinational handshake vectors, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_ifetch_buf;
    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    ifetch_buf_if bus ();

    ifetch_buf dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        req;
    } vec_t;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
        logic        e;
    } ent_t;

    vec_t vecs[6];

    ent_t        mq[$];
    bit          outst;
    bit          disc;
    logic [31:0] opc;
    bit          mem_pend;
    int          mem_wait;
    bit          e_rdy;
    bit          e_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one aligned fetch and return its data lat cycles after the request cycle.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
        bus.pc       = a;
        bus.pc_valid = 1'b1;
        #4;
        chk("fetch_req", bus.imem_req, 1);
        step();
        bus.pc_valid = 1'b0;
        repeat (lat - 1) step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        bus.pc          = 32'h0;
        bus.pc_valid    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;

        vecs[0] = '{pv: 1'b1, pc: 32'h0000_3000, fl: 1'b0, rdy: 1'b1, req: 1'b1};
        vecs[1] = '{pv: 1'b1, pc: 32'h0000_3002, fl: 1'b0, rdy: 1'b1, req: 1'b0};
        vecs[2] = '{pv: 1'b0, pc: 32'h0000_3000, fl: 1'b0, rdy: 1'b1, req: 1'b0};
        vecs[3] = '{pv: 1'b1, pc: 32'h0000_3004, fl: 1'b1, rdy: 1'b0, req: 1'b0};
        vecs[4] = '{pv: 1'b1, pc: 32'h0000_3001, fl: 1'b1, rdy: 1'b0, req: 1'b0};
        vecs[5] = '{pv: 1'b1, pc: 32'hFFFF_FFFC, fl: 1'b0, rdy: 1'b1, req: 1'b1};

        repeat (2) step();
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0000_3000);
        chk("rst_instr_exc", bus.instr_exc, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        Reset = 1'b0;
        #1;
        chk("post_rst_pc_ready", bus.pc_ready, 1);

        // Combinational handshake table, all applied inside one idle clock phase.
        foreach (vecs[i]) begin
            bus.pc_valid = vecs[i].pv;
            bus.pc       = vecs[i].pc;
            bus.flush    = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_pc_ready", i), bus.pc_ready, vecs[i].rdy);
            chk($sformatf("vec%0d_imem_req", i), bus.imem_req, vecs[i].req);
            if (vecs[i].req) chk($sformatf("vec%0d_imem_addr", i), bus.imem_addr, vecs[i].pc);
        end
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b0;
        step();

        // Single fetch, 2-cycle latency.
        bus.instr_ready = 1'b1;
        bus.pc          = 32'h0000_3000;
        bus.pc_valid    = 1'b1;
        #4;
        chk("single_req", bus.imem_req, 1);
        chk("single_addr", bus.imem_addr, 32'h0000_3000);
        step();
        bus.pc_valid = 1'b0;
        #4;
        chk("single_req_once", bus.imem_req, 0);
        chk("single_wait_ready", bus.pc_ready, 0);
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h3C01_0001;
        #4;
        chk("single_not_early", bus.instr_valid, 0);
        step();
        bus.imem_rvalid = 1'b0;
        #4;
        chk("single_valid", bus.instr_valid, 1);
        chk("single_instr", bus.instr, 32'h3C01_0001);
        chk("single_pc", bus.instr_pc, 32'h0000_3000);
        chk("single_exc", bus.instr_exc, 0);
        step();
        chk("single_popped", bus.instr_valid, 0);

        // Backpressure: two buffered, third refused until a pop.
        bus.instr_ready = 1'b0;
        fetch(32'h0000_3000, 32'h1111_0000, 1);
        fetch(32'h0000_3004, 32'h2222_0004, 1);
        bus.pc       = 32'h0000_3008;
        bus.pc_valid = 1'b1;
        #4;
        chk("bp_full_ready", bus.pc_ready, 0);
        chk("bp_full_req", bus.imem_req, 0);
        step();
        chk("bp_hold_pc", bus.instr_pc, 32'h0000_3000);
        chk("bp_hold_instr", bus.instr, 32'h1111_0000);
        bus.pc_valid    = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        #4;
        chk("bp_second_pc", bus.instr_pc, 32'h0000_3004);
        chk("bp_second_instr", bus.instr, 32'h2222_0004);
        chk("bp_ready_after_pop", bus.pc_ready, 1);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("bp_drained", bus.instr_valid, 0);

        // Misaligned PC becomes a fault entry with no memory request.
        bus.pc       = 32'h0000_3002;
        bus.pc_valid = 1'b1;
        #4;
        chk("mis_req", bus.imem_req, 0);
        chk("mis_ready", bus.pc_ready, 1);
        step();
        bus.pc_valid = 1'b0;
        chk("mis_valid", bus.instr_valid, 1);
        chk("mis_exc", bus.instr_exc, 1);
        chk("mis_instr", bus.instr, 0);
        chk("mis_pc", bus.instr_pc, 32'h0000_3002);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Flush one cycle after the request; response 3 cycles later is dropped.
        bus.pc       = 32'h0000_3008;
        bus.pc_valid = 1'b1;
        #4;
        chk("fl_req", bus.imem_req, 1);
        step();
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b1;
        bus.instr_ready = 1'b1;
        #4;
        chk("fl_ready_low", bus.pc_ready, 0);
        step();
        bus.flush = 1'b0;
        step();
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #4;
        chk("fl_drop_ready", bus.pc_ready, 0);
        step();
        bus.imem_rvalid = 1'b0;
        #4;
        chk("fl_idle_ready", bus.pc_ready, 1);
        chk("fl_no_word", bus.instr_valid, 0);

        // Flush coincident with the response.
        step();
        bus.pc       = 32'h0000_300C;
        bus.pc_valid = 1'b1;
        #4;
        chk("flc_req", bus.imem_req, 1);
        step();
        bus.pc_valid    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.flush       = 1'b1;
        step();
        bus.imem_rvalid = 1'b0;
        bus.flush       = 1'b0;
        #4;
        chk("flc_idle_ready", bus.pc_ready, 1);
        chk("flc_no_word", bus.instr_valid, 0);
        bus.instr_ready = 1'b0;
        step();

        // Async reset in WAIT with one entry buffered.
        fetch(32'h0000_3010, 32'h5555_AAAA, 1);
        bus.pc       = 32'h0000_3014;
        bus.pc_valid = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        chk("ar_pre_valid", bus.instr_valid, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("ar_valid", bus.instr_valid, 0);
        chk("ar_instr", bus.instr, 0);
        chk("ar_pc", bus.instr_pc, 32'h0000_3000);
        chk("ar_exc", bus.instr_exc, 0);
        chk("ar_req", bus.imem_req, 0);
        step();
        Reset = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h7777_7777;
        #4;
        chk("ar_idle_ready", bus.pc_ready, 1);
        step();
        bus.imem_rvalid = 1'b0;
        #4;
        chk("ar_late_rvalid", bus.instr_valid, 0);
        step();

        // Randomized traffic against the queue model; DUT is idle and empty here.
        outst    = 1'b0;
        disc     = 1'b0;
        opc      = 32'h0;
        mem_pend = 1'b0;
        mem_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.pc_valid = ($urandom_range(0, 3) != 0);
            bus.pc       = $urandom;
            if ($urandom_range(0, 3) != 0) bus.pc[1:0] = 2'b00;
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            if (mem_pend && mem_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = $urandom;
            end else if (!mem_pend && $urandom_range(0, 7) == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = $urandom;
            end else begin
                bus.imem_rvalid = 1'b0;
            end
            #4;
            e_rdy = !outst && (mq.size() < 2) && !bus.flush;
            e_req = e_rdy && bus.pc_valid && (bus.pc[1:0] == 2'b00);
            chk("rand_pc_ready", bus.pc_ready, e_rdy);
            chk("rand_imem_req", bus.imem_req, e_req);
            if (e_req) chk("rand_imem_addr", bus.imem_addr, bus.pc);
            chk("rand_instr_valid", bus.instr_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rand_instr", bus.instr, mq[0].w);
                chk("rand_instr_pc", bus.instr_pc, mq[0].a);
                chk("rand_instr_exc", bus.instr_exc, mq[0].e);
            end

            if (bus.flush) begin
                mq.delete();
                if (outst && bus.imem_rvalid) outst = 1'b0;
                else if (outst) disc = 1'b1;
            end else begin
                if (mq.size() > 0 && bus.instr_ready) void'(mq.pop_front());
                if (outst && bus.imem_rvalid) begin
                    if (!disc) mq.push_back('{w: bus.imem_rdata, a: opc, e: 1'b0});
                    outst = 1'b0;
                end else if (e_req) begin
                    outst = 1'b1;
                    disc  = 1'b0;
                    opc   = bus.pc;
                end else if (e_rdy && bus.pc_valid) begin
                    mq.push_back('{w: 32'h0, a: bus.pc, e: 1'b1});
                end
            end

            if (mem_pend && bus.imem_rvalid) mem_pend = 1'b0;
            else if (mem_pend) mem_wait--;
            if (e_req) begin
                mem_pend = 1'b1;
                mem_wait = $urandom_range(0, 2);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 SHALL have: Clk  input  1  the single system clock; all state changes on posedge.
REQ-002 SHALL have: Reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-003 SHALL have: pc  input  32  fetch address supplied by the PC register.
REQ-004 SHALL have: pc_valid  input  1  pc is a valid fetch request.
REQ-005 SHALL have: pc_ready  output  1  request accepted this cycle; PC register advances on pc_valid && pc_ready.
REQ-006 SHALL have: imem_req  output  1  instruction memory read strobe, one cycle per request.
REQ-007 SHALL have: imem_addr  output  32  instruction memory read address.
REQ-008 SHALL have: imem_rvalid  input  1  read data valid, arriving one or more cycles after imem_req.
REQ-009 SHALL have: imem_rdata  input  32  read data.
REQ-010 SHALL have: flush  input  1  discard all buffered and in-flight fetches.
REQ-011 SHALL have: instr_valid  output  1  head entry valid toward decode.
REQ-012 SHALL have: instr_ready  input  1  decode consumes the head entry on instr_valid && instr_ready.
REQ-013 SHALL have: instr  output  32  head instruction word.
REQ-014 SHALL have: instr_pc  output  32  address of the head instruction.
REQ-015 SHALL have: instr_exc  output  1  head entry is a misaligned-fetch fault.

Function
REQ-016 SHALL contain a 2-entry in-order FIFO of {instr, instr_pc, instr_exc}; the head drives the instr* outputs from registers.
REQ-017 SHALL implement FSM states IDLE (no read outstanding), WAIT (one read outstanding), DROP (outstanding read to be discarded).
REQ-018 SHALL drive pc_ready = (state==IDLE) && (count<2) && !flush; at most one read outstanding.
REQ-019 On acceptance with pc[1:0]==0, SHALL assert imem_req=1 and imem_addr=pc in the same cycle, latch pc, and go IDLE->WAIT.
REQ-020 On acceptance with pc[1:0]!=0, SHALL issue no imem_req, push {instr=0, pc, exc=1} into the FIFO at the next edge, and remain in IDLE.
REQ-021 When imem_rvalid is high in WAIT, SHALL push {imem_rdata, latched pc, exc=0} and go WAIT->IDLE; instr_valid rises no earlier than the edge after imem_rvalid.
REQ-022 SHALL ignore imem_rvalid in IDLE.
REQ-023 When imem_rvalid is high in DROP, SHALL discard the data and go DROP->IDLE.
REQ-024 SHALL drive instr_valid = (count>0); on a pop the next entry becomes the head at the following edge.
REQ-025 On a simultaneous push and pop, SHALL leave count unchanged and preserve order.
REQ-026 Flush SHALL have priority over push, pop and accept:
- count<=0 at the next edge.
- WAIT->DROP, or WAIT->IDLE if imem_rvalid is high in the same cycle (data discarded).
- IDLE and DROP unchanged.
REQ-027 SHALL perform no imem_req while flush is high.
REQ-028 SHALL hold head outputs stable while instr_valid && !instr_ready.

Reset
REQ-029 On Reset, SHALL asynchronously set:
- state=IDLE, count=0
- instr_valid=0, instr=0, instr_pc=0x00003000, instr_exc=0
- imem_req=0, latched pc=0x00003000
REQ-030 SHALL discard any read outstanding at reset; an imem_rvalid after reset release while in IDLE is ignored.
REQ-031 Reset asserted mid-WAIT SHALL return the block to IDLE within the same cycle, without waiting for a clock edge.

Verification
REQ-032 Single fetch:
- pc=0x00003000, rdata=0x3C010001 at 2-cycle latency, instr_ready=1.
- imem_req for one cycle; instr_valid one cycle after rvalid with instr_pc=0x00003000; pc_ready low during WAIT.
REQ-033 Backpressure:
- instr_ready=0, three sequential aligned pcs.
- Two entries buffered; pc_ready stays 0 until a pop; entries pop in order 0x3000, 0x3004.
REQ-034 Misaligned:
- pc=0x00003002.
- No imem_req; next cycle instr_valid=1, instr_exc=1, instr=0, instr_pc=0x00003002.
REQ-035 Flush in flight:
- flush one cycle after imem_req to 0x3008; rvalid 3 cycles later with 0xDEADBEEF.
- Word never appears; state DROP->IDLE; pc_ready=1 the cycle after rvalid.
- Repeat with flush coincident with rvalid: data discarded, IDLE next cycle.
REQ-036 Async reset:
- Assert Reset between clock edges while in WAIT with one entry buffered.
- Outputs reach reset values before the next posedge; a later rvalid produces no entry.
